// File: rtl/vt52_pkg.sv
// vt52_pkg: screen geometry, character codes and writer state encoding
package vt52_pkg;
  localparam int ROWS = 24;
  localparam int COLS = 80;
  localparam int ROW_BITS = 5;
  localparam int COL_BITS = 7;
  localparam int ADDR_BITS = 11;
  localparam int SCREEN_SIZE = ROWS * COLS;
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);
  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
  localparam logic [ADDR_BITS-1:0] COLS_A = ADDR_BITS'(COLS);
  localparam logic [ADDR_BITS-1:0] LAST_COL_A = ADDR_BITS'(COLS - 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(SCREEN_SIZE - 1);
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] BS = 8'h08;
  localparam logic [7:0] FF = 8'h0C;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] TILDE = 8'h7E;
  typedef enum logic [1:0] {IDLE, CLR_ROW, CLR_SCREEN} state_t;
  function automatic logic printable(input logic [7:0] c);
    return c >= SPACE && c <= TILDE;
  endfunction
endpackage

// File: rtl/addr_wrap_add.sv
// addr_wrap_add: (a + b) mod SCREEN_SIZE for a < SCREEN_SIZE and b <= COLS
module addr_wrap_add import vt52_pkg::*; (
  input  logic [ADDR_BITS-1:0] a,
  input  logic [ADDR_BITS-1:0] b,
  output logic [ADDR_BITS-1:0] y
);
  localparam logic [ADDR_BITS:0] SIZE = (ADDR_BITS + 1)'(SCREEN_SIZE);
  logic [ADDR_BITS:0] s;
  assign s = {1'b0, a} + {1'b0, b};
  assign y = s >= SIZE ? ADDR_BITS'(s - SIZE) : s[ADDR_BITS-1:0];
endmodule

// File: rtl/screen_writer.sv
// screen_writer: sequences character, scroll and clear writes into the 80x24 text buffer
module screen_writer import vt52_pkg::*; (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic [7:0]           in_char,
  output logic                 in_ready,
  output logic [ROW_BITS-1:0]  cursor_row,
  output logic [COL_BITS-1:0]  cursor_col,
  output logic [ADDR_BITS-1:0] buffer_waddr,
  output logic [7:0]           buffer_din,
  output logic                 buffer_wen,
  output logic [ADDR_BITS-1:0] buffer_first_char,
  output logic                 buffer_first_char_wen
);
  state_t state, state_n;
  logic [ROW_BITS-1:0] row_n;
  logic [COL_BITS-1:0] col_n;
  logic [ADDR_BITS-1:0] fc_n, cur, cur_n, row_addr, row_addr_n, clr_ptr, clr_ptr_n, cnt, cnt_n, waddr_n;
  logic [ADDR_BITS-1:0] cur_inc, cur_sum, row_sum, clr_sum, fc_sum;
  logic [7:0] din_n;
  logic wen_n, fc_wen_n, lf;
  assign cur_inc = in_char == LF ? COLS_A : ADDR_BITS'(1);
  addr_wrap_add u_cur (.a(cur), .b(cur_inc), .y(cur_sum));
  addr_wrap_add u_row (.a(row_addr), .b(COLS_A), .y(row_sum));
  addr_wrap_add u_clr (.a(clr_ptr), .b(ADDR_BITS'(1)), .y(clr_sum));
  addr_wrap_add u_fc (.a(buffer_first_char), .b(COLS_A), .y(fc_sum));
  // decode accepted bytes, advance cursor/scroll state and walk the clear pointer
  always_comb begin
    state_n = state;
    row_n = cursor_row;
    col_n = cursor_col;
    fc_n = buffer_first_char;
    cur_n = cur;
    row_addr_n = row_addr;
    clr_ptr_n = clr_ptr;
    cnt_n = cnt;
    waddr_n = buffer_waddr;
    din_n = buffer_din;
    wen_n = 1'b0;
    fc_wen_n = 1'b0;
    lf = 1'b0;
    if (state == IDLE && in_valid) begin
      if (printable(in_char)) begin
        waddr_n = cur;
        din_n = in_char;
        wen_n = 1'b1;
        cur_n = cur_sum;
        lf = cursor_col == LAST_COL;
        col_n = lf ? '0 : cursor_col + 1'b1;
      end else if (in_char == CR) begin
        col_n = '0;
        cur_n = row_addr;
      end else if (in_char == LF) begin
        cur_n = cur_sum;
        lf = 1'b1;
      end else if (in_char == BS && cursor_col != '0) begin
        col_n = cursor_col - 1'b1;
        cur_n = cur == '0 ? LAST_ADDR : cur - 1'b1;
      end else if (in_char == FF) begin
        row_n = '0;
        col_n = '0;
        fc_n = '0;
        cur_n = '0;
        row_addr_n = '0;
        clr_ptr_n = '0;
        cnt_n = '0;
        state_n = CLR_SCREEN;
      end
    end
    if (lf) begin
      row_addr_n = row_sum;
      row_n = cursor_row == LAST_ROW ? cursor_row : cursor_row + 1'b1;
      if (cursor_row == LAST_ROW) begin
        fc_n = fc_sum;
        clr_ptr_n = buffer_first_char;
        cnt_n = '0;
        state_n = CLR_ROW;
      end
    end
    if (state != IDLE) begin
      waddr_n = clr_ptr;
      din_n = SPACE;
      wen_n = 1'b1;
      fc_wen_n = cnt == '0;
      clr_ptr_n = clr_sum;
      cnt_n = cnt + 1'b1;
      state_n = cnt == (state == CLR_ROW ? LAST_COL_A : LAST_ADDR) ? IDLE : state;
    end
  end
  // register state and every output; reset aborts any clear in progress
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      in_ready <= 1'b1;
      cursor_row <= '0;
      cursor_col <= '0;
      buffer_first_char <= '0;
      cur <= '0;
      row_addr <= '0;
      clr_ptr <= '0;
      cnt <= '0;
      buffer_waddr <= '0;
      buffer_din <= '0;
      buffer_wen <= 1'b0;
      buffer_first_char_wen <= 1'b0;
    end else begin
      state <= state_n;
      in_ready <= state_n == IDLE;
      cursor_row <= row_n;
      cursor_col <= col_n;
      buffer_first_char <= fc_n;
      cur <= cur_n;
      row_addr <= row_addr_n;
      clr_ptr <= clr_ptr_n;
      cnt <= cnt_n;
      buffer_waddr <= waddr_n;
      buffer_din <= din_n;
      buffer_wen <= wen_n;
      buffer_first_char_wen <= fc_wen_n;
    end
  end
endmodule

// File: tb/tb_screen_writer.sv
// tb_screen_writer: randomized scoreboard bench against a row/column screen model
module tb_screen_writer;
  logic clk = 1'b0;
  logic clr, in_valid, in_ready, buffer_wen, buffer_first_char_wen;
  logic [7:0] in_char, buffer_din;
  logic [4:0] cursor_row;
  logic [6:0] cursor_col;
  logic [10:0] buffer_waddr, buffer_first_char;
  int cmp = 0;
  int errs = 0;
  int row, col, fc, busy_exp;
  logic [18:0] wq[$];
  int fq[$];
  screen_writer dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .buffer_waddr(buffer_waddr),
    .buffer_din(buffer_din), .buffer_wen(buffer_wen), .buffer_first_char(buffer_first_char),
    .buffer_first_char_wen(buffer_first_char_wen)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    cmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    row = 0;
    col = 0;
    fc = 0;
    busy_exp = 0;
    wq.delete();
    fq.delete();
  endtask
  task automatic newline();
    if (row < 23) row++;
    else begin
      fc = (fc + 80) % 1920;
      fq.push_back(fc);
      for (int i = 0; i < 80; i++) wq.push_back({11'((fc + 23 * 80 + i) % 1920), 8'h20});
      busy_exp = 80;
    end
  endtask
  task automatic model(input logic [7:0] c);
    busy_exp = 0;
    if (c >= 8'h20 && c <= 8'h7E) begin
      wq.push_back({11'((fc + row * 80 + col) % 1920), c});
      if (col == 79) begin
        col = 0;
        newline();
      end else col++;
    end else if (c == 8'h0D) col = 0;
    else if (c == 8'h0A) newline();
    else if (c == 8'h08) begin
      if (col > 0) col--;
    end else if (c == 8'h0C) begin
      row = 0;
      col = 0;
      fc = 0;
      fq.push_back(0);
      for (int i = 0; i < 1920; i++) wq.push_back({11'(i), 8'h20});
      busy_exp = 1920;
    end
  endtask
  task automatic send(input logic [7:0] c);
    int n = 0;
    in_valid = 1'b1;
    in_char = c;
    while (!in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("busy_cycles", n, busy_exp);
    if (in_ready) begin
      model(c);
      @(negedge clk);
      in_valid = 1'b0;
      chk("cursor_row", int'(cursor_row), row);
      chk("cursor_col", int'(cursor_col), col);
    end else in_valid = 1'b0;
  endtask
  task automatic idle(input int k);
    in_valid = 1'b0;
    repeat (k) @(negedge clk);
    busy_exp = busy_exp > k ? busy_exp - k : 0;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_row"}, int'(cursor_row), 0);
    chk({tag, "_col"}, int'(cursor_col), 0);
    chk({tag, "_waddr"}, int'(buffer_waddr), 0);
    chk({tag, "_din"}, int'(buffer_din), 0);
    chk({tag, "_wen"}, int'(buffer_wen), 0);
    chk({tag, "_first_char"}, int'(buffer_first_char), 0);
    chk({tag, "_first_char_wen"}, int'(buffer_first_char_wen), 0);
  endtask
  // scoreboard monitor: every write and first_char load is popped and compared
  always @(negedge clk) begin
    if (buffer_wen) begin
      chk("write_pending", int'(wq.size() > 0), 1);
      if (wq.size() > 0) begin
        logic [18:0] e;
        e = wq.pop_front();
        chk("waddr", int'(buffer_waddr), int'(e[18:8]));
        chk("din", int'(buffer_din), int'(e[7:0]));
      end
    end
    if (buffer_first_char_wen) begin
      chk("first_char_pending", int'(fq.size() > 0), 1);
      chk("first_char_with_write", int'(buffer_wen), 1);
      if (fq.size() > 0) chk("first_char", int'(buffer_first_char), fq.pop_front());
    end
  end
  initial begin
    clr = 1'b1;
    in_valid = 1'b0;
    in_char = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    clr = 1'b0;
    @(negedge clk);
    send(8'h41);
    send(8'h0D);
    for (int i = 0; i < 80; i++) send(8'($urandom_range(32, 126)));
    for (int i = 0; i < 46; i++) send(8'h0A);
    send(8'h0D);
    send(8'h08);
    send(8'h42);
    send(8'h08);
    send(8'h08);
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [7:0] c;
      r = $urandom_range(0, 99);
      c = r < 60 ? 8'($urandom_range(32, 126)) : r < 72 ? 8'h0A : r < 80 ? 8'h0D :
          r < 90 ? 8'h08 : 8'($urandom_range(0, 255));
      send(c);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 90));
    end
    send(8'h0C);
    send(8'h5A);
    send(8'h0C);
    idle(500);
    #2;
    clr = 1'b1;
    model_reset();
    @(negedge clk);
    chk_reset_outputs("midclear");
    #2;
    clr = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", int'(in_ready), 1);
    for (int i = 0; i < 40; i++) send(8'($urandom_range(32, 126)));
    for (int i = 0; i < 3000 && wq.size() > 0; i++) @(negedge clk);
    idle(4);
    chk("writes_left", wq.size(), 0);
    chk("first_char_loads_left", fq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
